// File: rtl/debug_frame_tx.sv
// Capture-byte FIFO plus framer: SOF, SEQ, LEN, payload and optional XOR check byte on a valid/ready stream.
// DEBUG_FRAME_TX_CHECKSUM_EN adds the trailing CHK byte; without it tx_last rides the final payload byte.
module debug_frame_tx #(
  parameter int         FIFO_AW       = 4,
  parameter int         MAX_PAYLOAD   = 8,
  parameter int         FLUSH_TIMEOUT = 1000,
  parameter logic [7:0] SOF_BYTE      = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic [7:0]       data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] MAXP_C  = (FIFO_AW+1)'(MAX_PAYLOAD);
  localparam logic [TW-1:0]    TMO_C   = TW'(FLUSH_TIMEOUT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOF  = 3'd1;
  localparam logic [2:0] S_SEQ  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd5;
  logic [7:0] chk_q, chk_d;
`endif

  logic [2:0]         state_q, state_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         seq_q, seq_d, len_q, len_d, pay_cnt_q, pay_cnt_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [DEPTH];
  logic               wr_en, rd_en, xfer, pay_last;
  logic [7:0]         head;

  // Write acceptance looks only at the occupancy at this edge, never at a same-cycle pop.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    wr_en    = trigger && (count_q < DEPTH_C);
    xfer     = tx_valid && tx_ready;
    rd_en    = (state_q == S_PAY) && xfer;
    pay_last = (pay_cnt_q == len_q - 8'd1);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q | (trigger & ~wr_en);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    seq_d     = seq_q;
    len_d     = len_q;
    pay_cnt_d = pay_cnt_q;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!wr_en && count_q != '0)
          timer_d = (timer_q == TMO_C) ? timer_q : timer_q + 1'b1;
        if (count_q >= MAXP_C || (timer_q == TMO_C && count_q != '0)) begin
          state_d   = S_SOF;
          len_d     = (count_q >= MAXP_C) ? 8'(MAX_PAYLOAD) : 8'(count_q);
          pay_cnt_d = '0;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      S_SOF: if (xfer) state_d = S_SEQ;
      S_SEQ: if (xfer) begin
        state_d = S_LEN;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
        chk_d   = chk_q ^ seq_q;
`endif
      end
      S_LEN: if (xfer) begin
        state_d = S_PAY;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
        chk_d   = chk_q ^ len_q;
`endif
      end
      S_PAY: if (xfer) begin
        pay_cnt_d = pay_cnt_q + 8'd1;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
        chk_d     = chk_q ^ head;
        if (pay_last) state_d = S_CHK;
`else
        if (pay_last) begin
          state_d = S_IDLE;
          seq_d   = seq_q + 8'd1;
        end
`endif
      end
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      S_CHK: if (xfer) begin
        state_d = S_IDLE;
        seq_d   = seq_q + 8'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (state_q != S_IDLE);
    tx_data  = '0;
    tx_last  = 1'b0;
    case (state_q)
      S_SOF: tx_data = SOF_BYTE;
      S_SEQ: tx_data = seq_q;
      S_LEN: tx_data = len_q;
      S_PAY: begin
        tx_data = head;
`ifndef DEBUG_FRAME_TX_CHECKSUM_EN
        tx_last = pay_last;
`endif
      end
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      S_CHK: begin
        tx_data = chk_q;
        tx_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign overflow   = ovf_q;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      seq_q     <= '0;
      len_q     <= '0;
      pay_cnt_q <= '0;
      ovf_q     <= 1'b0;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      seq_q     <= seq_d;
      len_q     <= len_d;
      pay_cnt_q <= pay_cnt_d;
      ovf_q     <= ovf_d;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end
endmodule
